// File: rtl/sd_init_seq.sv
// sd_init_seq: SD card identification sequencer (CMD0/8/55/41/2/3/7/16) driving a single command controller
module sd_init_seq #(
  parameter logic [15:0] SLOW_CLKDIV    = 16'd48,
  parameter logic [15:0] FAST_CLKDIV    = 16'd1,
  parameter logic [15:0] INIT_PRECYCLES = 16'd80,
  parameter logic [15:0] GAP_PRECYCLES  = 16'd8,
  parameter logic [15:0] ACMD41_RETRIES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_start,
  output logic        init_busy,
  output logic        card_ready,
  output logic        init_error,
  output logic [3:0]  err_code,
  output logic        card_sdhc,
  output logic [15:0] card_rca,
  output logic        cmd_start,
  output logic [15:0] cmd_precycles,
  output logic [15:0] cmd_clkdiv,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  input  logic [31:0] cmd_resparg,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic        cmd_syntaxerr
);
  typedef enum logic [2:0] {S_IDLE, S_READY, S_ERROR, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [2:0] {C0, C8, C55, A41, C2, C3, C7, C16} step_t;
  localparam logic [15:0] RETRY_LOAD = (ACMD41_RETRIES == 16'd0) ? 16'd1 : ACMD41_RETRIES;
  state_t      r_state, w_state;
  step_t       r_step, w_step;
  logic        r_hcs, w_hcs, r_sdhc, w_sdhc, r_ready, w_ready, r_error, w_error, r_start, w_start;
  logic [3:0]  r_err_code, w_err_code, w_fail;
  logic [15:0] r_rca, w_rca, r_clkdiv, w_clkdiv, r_cnt, w_cnt, r_pre, w_pre;
  logic [5:0]  r_idx, w_idx;
  logic [31:0] r_arg, w_arg;
  logic        w_to_se, w_unused;
  assign w_to_se  = cmd_timeout | cmd_syntaxerr;
  assign w_unused = ^cmd_resparg[15:12];
  always_comb begin
    w_state    = r_state;
    w_step     = r_step;
    w_hcs      = r_hcs;
    w_sdhc     = r_sdhc;
    w_rca      = r_rca;
    w_clkdiv   = r_clkdiv;
    w_cnt      = r_cnt;
    w_ready    = r_ready;
    w_error    = r_error;
    w_err_code = r_err_code;
    w_start    = 1'b0;
    w_fail     = 4'd0;
    case (r_state)
      S_IDLE, S_READY, S_ERROR: if (init_start) begin
        w_state    = S_ISSUE;
        w_step     = C0;
        w_hcs      = 1'b0;
        w_sdhc     = 1'b0;
        w_rca      = 16'd0;
        w_clkdiv   = SLOW_CLKDIV;
        w_cnt      = RETRY_LOAD;
        w_ready    = 1'b0;
        w_error    = 1'b0;
        w_err_code = 4'd0;
      end
      S_ISSUE: if (!cmd_busy) begin
        w_start = 1'b1;
        w_state = S_WAIT;
      end
      S_WAIT: if (cmd_done) begin
        w_state = S_ISSUE;
        case (r_step)
          C0:  w_step = C8;
          C8:  if (cmd_timeout) begin
                 w_hcs  = 1'b0;
                 w_step = C55;
               end else if (cmd_syntaxerr || cmd_resparg[11:0] != 12'h1AA) w_fail = 4'd2;
               else begin
                 w_hcs  = 1'b1;
                 w_step = C55;
               end
          C55: if (w_to_se) w_fail = 4'd3; else w_step = A41;
          A41: if (cmd_timeout) w_fail = 4'd4;
               else if (cmd_resparg[31]) begin
                 w_sdhc = cmd_resparg[30];
                 w_step = C2;
               end else begin
                 w_cnt = (r_cnt == 16'd0) ? 16'd0 : r_cnt - 16'd1;
                 if (w_cnt == 16'd0) w_fail = 4'd5; else w_step = C55;
               end
          C2:  if (cmd_timeout) w_fail = 4'd6; else w_step = C3;
          C3:  if (w_to_se) w_fail = 4'd7;
               else begin
                 w_rca    = cmd_resparg[31:16];
                 w_clkdiv = FAST_CLKDIV;
                 w_step   = C7;
               end
          C7:  if (w_to_se) w_fail = 4'd8; else w_step = C16;
          C16: if (w_to_se) w_fail = 4'd9;
               else begin
                 w_state = S_READY;
                 w_ready = 1'b1;
               end
        endcase
        if (w_fail != 4'd0) begin
          w_state    = S_ERROR;
          w_error    = 1'b1;
          w_err_code = w_fail;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_comb begin
    w_idx = 6'd0;
    w_arg = 32'd0;
    case (w_step)
      C8:      begin w_idx = 6'd8;  w_arg = 32'h0000_01AA; end
      C55:     w_idx = 6'd55;
      A41:     begin w_idx = 6'd41; w_arg = w_hcs ? 32'h40FF_8000 : 32'h00FF_8000; end
      C2:      w_idx = 6'd2;
      C3:      w_idx = 6'd3;
      C7:      begin w_idx = 6'd7;  w_arg = {w_rca, 16'h0000}; end
      C16:     begin w_idx = 6'd16; w_arg = 32'h0000_0200; end
      default: ;
    endcase
    w_pre = (w_step == C0) ? INIT_PRECYCLES : GAP_PRECYCLES;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_step     <= C0;
      r_hcs      <= 1'b0;
      r_sdhc     <= 1'b0;
      r_rca      <= 16'd0;
      r_clkdiv   <= SLOW_CLKDIV;
      r_cnt      <= 16'd0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 4'd0;
      r_start    <= 1'b0;
      r_idx      <= 6'd0;
      r_arg      <= 32'd0;
      r_pre      <= 16'd0;
    end else begin
      r_state    <= w_state;
      r_step     <= w_step;
      r_hcs      <= w_hcs;
      r_sdhc     <= w_sdhc;
      r_rca      <= w_rca;
      r_clkdiv   <= w_clkdiv;
      r_cnt      <= w_cnt;
      r_ready    <= w_ready;
      r_error    <= w_error;
      r_err_code <= w_err_code;
      r_start    <= w_start;
      if (w_state == S_ISSUE) begin
        r_idx <= w_idx;
        r_arg <= w_arg;
        r_pre <= w_pre;
      end
    end
  end
  assign init_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign card_ready    = r_ready;
  assign init_error    = r_error;
  assign err_code      = r_err_code;
  assign card_sdhc     = r_sdhc;
  assign card_rca      = r_rca;
  assign cmd_start     = r_start;
  assign cmd_precycles = r_pre;
  assign cmd_clkdiv    = r_clkdiv;
  assign cmd_idx       = r_idx;
  assign cmd_arg       = r_arg;
endmodule

// File: doc/sd_init_seq.md
# sd_init_seq

SD card power-up initialization sequencer. It drives the single-bit SD command controller's user port through the fixed identification flow: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7, CMD16. It captures card type (SDHC) and RCA, switches the SD clock divider from slow to fast after identification, and reports ready or a coded error to the storage front-end. It sits between the system control logic and the command controller; it is the command controller's only requester during init.

## Interface

- `SLOW_CLKDIV`, 16'd48: clkdiv used for CMD0 through CMD3 (identification rate, ≤400 kHz).
- `FAST_CLKDIV`, 16'd1: clkdiv used from CMD7 onward.
- `INIT_PRECYCLES`, 16'd80: precycles for CMD0 (≥74 card power-up clocks).
- `GAP_PRECYCLES`, 16'd8: precycles for every other command.
- `ACMD41_RETRIES`, 16'd1000: max ACMD41 attempts; 0 is treated as 1.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `init_start` in 1: pulse; starts or restarts the sequence.
- `init_busy` out 1: high while the sequence is running.
- `card_ready` out 1: high after CMD16 succeeds, until next `init_start` or reset.
- `init_error` out 1: high after a failure, until next `init_start` or reset.
- `err_code` out 4: failing step code; 0 when no error.
- `card_sdhc` out 1: card accepted HCS (block addressing).
- `card_rca` out 16: RCA from CMD3.
- `cmd_start` out 1: one-cycle start pulse to the command controller.
- `cmd_precycles` out 16, `cmd_clkdiv` out 16, `cmd_idx` out 6, `cmd_arg` out 32: command request fields.
- `cmd_resparg` in 32: response argument bits [127:96] of the controller's response register.
- `cmd_busy`, `cmd_done`, `cmd_timeout`, `cmd_syntaxerr` in 1 each: controller status. `cmd_done` is a one-cycle pulse while `cmd_busy` is high; `cmd_timeout` and `cmd_syntaxerr` are valid in that cycle.

## Operation

- **States:**
  - `IDLE`, `READY`, `ERROR` are rest states.
  - `ISSUE` presents the command.
  - `WAIT` waits for `cmd_done`.
  - A `step` register (CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, CMD7, CMD16) selects the command.
- **Start:** `init_start` in a rest state clears `card_ready`, `init_error`, `err_code`, `card_sdhc` and `card_rca`. It loads the retry counter, sets `step`=CMD0, sets `cmd_clkdiv`=`SLOW_CLKDIV`, and goes to `ISSUE`. `init_start` is ignored in `ISSUE` and `WAIT`.
- **ISSUE:** holds until `cmd_busy`=0, then pulses `cmd_start` for exactly one cycle and goes to `WAIT`. Request fields are registered; they are stable from entry to `ISSUE` until `WAIT` exits.
- **WAIT:** in the cycle `cmd_done`=1, evaluates `step` and goes to the next `ISSUE`, `READY` or `ERROR`.
- **Per-step evaluation, in order:**
  - **CMD0**, arg 0, `INIT_PRECYCLES`: timeout is expected. Any result → CMD8.
  - **CMD8**, arg 0x000001AA:
    - timeout → v1 card, hcs=0, → CMD55.
    - syntaxerr, or `cmd_resparg[11:0]`≠0x1AA → error 2.
    - otherwise hcs=1, → CMD55.
  - **CMD55**, arg 0: timeout or syntaxerr → error 3. Otherwise → ACMD41.
  - **ACMD41** (idx 41), arg 0x40FF8000 if hcs else 0x00FF8000:
    - timeout → error 4.
    - `cmd_resparg[31]`=1 → `card_sdhc`=`cmd_resparg[30]`, → CMD2.
    - else decrement the counter; reaching 0 → error 5, otherwise → CMD55.
    - syntaxerr is ignored, because the R3 cmd field is 0x3F.
  - **CMD2**, arg 0: timeout → error 6. Otherwise → CMD3.
  - **CMD3**, arg 0: timeout or syntaxerr → error 7. Otherwise `card_rca`=`cmd_resparg[31:16]`, `cmd_clkdiv`←`FAST_CLKDIV`, → CMD7.
  - **CMD7**, arg {`card_rca`,16'h0}: timeout or syntaxerr → error 8. Otherwise → CMD16.
  - **CMD16**, arg 0x00000200: timeout or syntaxerr → error 9. Otherwise → `READY`.
- **ERROR:** sets `init_error`=1 and latches `err_code`.
- **Reset values:** all outputs 0 except `cmd_clkdiv`=`SLOW_CLKDIV`. Reset mid-sequence returns to `IDLE` immediately with no further `cmd_start`. The command controller shares `rst_n`.

## Timing

- `cmd_start` is asserted one cycle after `ISSUE` is entered with `cmd_busy`=0. It is never asserted while `cmd_busy`=1. It is asserted at most once per `WAIT`.
- `WAIT` → next `ISSUE` takes 1 cycle. Because `cmd_busy` drops the cycle after `cmd_done`, the next `cmd_start` occurs at earliest 2 cycles after `cmd_done`.
- `card_ready`, `init_error`, `err_code`, `card_sdhc` and `card_rca` update in the cycle after the relevant `cmd_done`.
- `init_busy`=1 exactly while in `ISSUE` or `WAIT`.
- The retry counter is 16-bit and never wraps below 0.

## Test plan

- **SDHC card model:** CMD0 times out, CMD8 echoes 0x1AA, ACMD41 is ready on the 3rd try with bit30=1, CMD3 returns RCA 0x1234 → command order CMD0,8,55,41,55,41,55,41,2,3,7,16.
  - CMD7 arg = 0x12340000.
  - `cmd_clkdiv` = 48 through CMD3 and 1 from CMD7.
  - Ends with `card_ready`=1, `card_sdhc`=1, `err_code`=0.
- **v1 card:** CMD8 times out → ACMD41 args are 0x00FF8000, `card_sdhc`=0, `card_ready`=1.
- **Retry exhaustion:** `ACMD41_RETRIES`=4 and ACMD41 never ready → exactly 4 ACMD41 commands, then `init_error`=1 and `err_code`=5.
- **Bad CMD8 echo:** CMD8 returns 0x1A5 → `err_code`=2 with no further `cmd_start`.
  - A subsequent `init_start` with a good model reaches `READY` and clears `err_code`.
- **Handshake:** hold `cmd_busy`=1 for 20 cycles after `cmd_done` → `cmd_start` is delayed until `cmd_busy`=0. `init_start` pulsed during `WAIT` is ignored.
- **Reset:** assert `rst_n`=0 for 1 cycle mid-ACMD41 loop → all outputs at reset values next cycle, then no `cmd_start` until `init_start`.
